// File: rtl/axis_pulse_gen.sv
// axis_pulse_gen
//   AXI-Stream pulse-train source for the DAC path. Each pulse is a baseline,
//   a linear ramp up, a flat top, a ramp down and a second baseline; pulses
//   repeat back to back while enable is held.
//
// Ports
//   aclk, areset   clock, asynchronous active-high reset
//   cfg_data       {enable, step, high_level, low_level, width, ramp}
//   case_id        state of the sample currently presented
//   sts_data       completed-pulse count (wraps)
//   m_axis_*       AXI-Stream master (registered tdata/tvalid/tlast)
module axis_pulse_gen #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int PULSE_WIDTH      = 16,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                                          aclk,
  input  logic                                          areset,
  input  logic [2*PULSE_WIDTH+3*AXIS_TDATA_WIDTH:0]     cfg_data,
  output logic [2:0]                                    case_id,
  output logic [31:0]                                   sts_data,
  input  logic                                          m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]                   m_axis_tdata,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast
);

  localparam int D  = AXIS_TDATA_WIDTH;
  localparam int PW = PULSE_WIDTH;
  localparam int CW = CNTR_WIDTH;
  localparam int AW = D + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW_PRE   = 3'd1,
    RAMP_UP   = 3'd2,
    HIGH      = 3'd3,
    RAMP_DOWN = 3'd4,
    LOW_POST  = 3'd5
  } state_t;

  // Number of beats a state emits for a given configuration.
  function automatic logic [CW-1:0] state_len(state_t s, logic [PW-1:0] ramp,
                                              logic [PW-1:0] width);
    logic [CW-1:0] n;
    n = '0;
    case (s)
      LOW_PRE, LOW_POST: n = CW'(width >> 1);
      RAMP_UP, RAMP_DOWN: n = CW'(ramp);
      HIGH:               n = CW'(width);
      default:            n = '0;
    endcase
    return n;
  endfunction

  // First state after s that emits at least one beat; IDLE when none remain.
  function automatic state_t next_after(state_t s, logic [PW-1:0] ramp,
                                        logic [PW-1:0] width);
    state_t n;
    logic   half_nz;
    n       = IDLE;
    half_nz = |(width >> 1);
    case (s)
      IDLE, LOW_PRE: begin
        if (|ramp)       n = RAMP_UP;
        else if (|width) n = HIGH;
      end
      RAMP_UP: begin
        if (|width)      n = HIGH;
        else if (|ramp)  n = RAMP_DOWN;
      end
      HIGH: begin
        if (|ramp)       n = RAMP_DOWN;
        else if (half_nz) n = LOW_POST;
      end
      RAMP_DOWN: begin
        if (half_nz)     n = LOW_POST;
      end
      default: n = IDLE;
    endcase
    return n;
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ramp, r_width;
  logic [D-1:0]    r_low, r_high, r_step;
  logic [D-1:0]    r_tdata;
  logic            r_tvalid, r_tlast;
  logic [31:0]     r_sts;

  logic            w_en, w_xfer, w_start, w_stop, w_adv;
  logic [PW-1:0]   w_cfg_ramp, w_cfg_width, w_c_ramp, w_c_width;
  logic [D-1:0]    w_cfg_low, w_cfg_high, w_cfg_step;
  logic [D-1:0]    w_c_low, w_c_high, w_c_step;
  state_t          w_nx_state;
  logic [CW-1:0]   w_nx_cnt, w_nx_len, w_cur_len;
  logic [CW:0]     w_cnt_inc, w_nx_inc;
  logic [D-1:0]    w_nx_data;
  logic            w_nx_last;
  logic signed [AW-1:0] w_lo, w_hi, w_stp, w_cur, w_base, w_sum, w_val;

  assign w_cfg_ramp  = cfg_data[PW-1:0];
  assign w_cfg_width = cfg_data[2*PW-1:PW];
  assign w_cfg_low   = cfg_data[2*PW+D-1:2*PW];
  assign w_cfg_high  = cfg_data[2*PW+2*D-1:2*PW+D];
  assign w_cfg_step  = cfg_data[2*PW+3*D-1:2*PW+2*D];
  assign w_en        = cfg_data[2*PW+3*D];

  assign w_xfer  = r_tvalid & m_axis_tready;
  assign w_start = w_en & ((r_state == IDLE) | (w_xfer & r_tlast));
  assign w_stop  = w_xfer & r_tlast & ~w_en;
  assign w_adv   = w_xfer & ~r_tlast;

  // A new pulse computes its first beat from the incoming config, which is
  // captured into the shadow registers on the same edge.
  assign w_c_ramp  = w_start ? w_cfg_ramp  : r_ramp;
  assign w_c_width = w_start ? w_cfg_width : r_width;
  assign w_c_low   = w_start ? w_cfg_low   : r_low;
  assign w_c_high  = w_start ? w_cfg_high  : r_high;
  assign w_c_step  = w_start ? w_cfg_step  : r_step;

  assign w_lo  = {{2{w_c_low[D-1]}}, w_c_low};
  assign w_hi  = {{2{w_c_high[D-1]}}, w_c_high};
  assign w_stp = {2'b00, w_c_step};
  assign w_cur = {{2{r_tdata[D-1]}}, r_tdata};

  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_cur_len  = state_len(r_state, w_c_ramp, w_c_width);
    w_cnt_inc  = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
    if (w_start) begin
      // All-zero lengths fall back to one LOW_PRE beat so the stream never stalls.
      if (state_len(LOW_PRE, w_c_ramp, w_c_width) != '0) begin
        w_nx_state = LOW_PRE;
      end else begin
        w_nx_state = next_after(LOW_PRE, w_c_ramp, w_c_width);
        if (w_nx_state == IDLE) w_nx_state = LOW_PRE;
      end
      w_nx_cnt = '0;
    end else if (w_cnt_inc < {1'b0, w_cur_len}) begin
      w_nx_cnt = w_cnt_inc[CW-1:0];
    end else begin
      w_nx_state = next_after(r_state, w_c_ramp, w_c_width);
      w_nx_cnt   = '0;
    end

    w_nx_len = state_len(w_nx_state, w_c_ramp, w_c_width);
    w_nx_inc = {1'b0, w_nx_cnt} + {{CW{1'b0}}, 1'b1};

    // Ramps continue from the previously presented sample; the wide
    // accumulator lets the clamp act before any truncation.
    w_base = w_lo;
    w_sum  = w_lo;
    w_val  = w_lo;
    case (w_nx_state)
      RAMP_UP: begin
        w_base = (w_nx_cnt == '0) ? w_lo : w_cur;
        w_sum  = w_base + w_stp;
        w_val  = (w_sum > w_hi) ? w_hi : w_sum;
      end
      RAMP_DOWN: begin
        w_base = (w_nx_cnt == '0) ? w_hi : w_cur;
        w_sum  = w_base - w_stp;
        w_val  = (w_sum < w_lo) ? w_lo : w_sum;
      end
      HIGH:    w_val = w_hi;
      default: w_val = w_lo;
    endcase
    w_nx_data = w_val[D-1:0];
    w_nx_last = (w_nx_inc >= {1'b0, w_nx_len}) &&
                (next_after(w_nx_state, w_c_ramp, w_c_width) == IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_width  <= '0;
      r_low    <= '0;
      r_high   <= '0;
      r_step   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_sts    <= '0;
    end else begin
      if (w_xfer & r_tlast) r_sts <= r_sts + 32'd1;
      if (w_start) begin
        r_ramp  <= w_cfg_ramp;
        r_width <= w_cfg_width;
        r_low   <= w_cfg_low;
        r_high  <= w_cfg_high;
        r_step  <= w_cfg_step;
      end
      if (w_start | w_adv) begin
        r_state  <= w_nx_state;
        r_cnt    <= w_nx_cnt;
        r_tdata  <= w_nx_data;
        r_tlast  <= w_nx_last;
        r_tvalid <= 1'b1;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign case_id       = r_state;
  assign sts_data      = r_sts;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_pulse_gen.sv
// tb_axis_pulse_gen
//   Self-checking bench for axis_pulse_gen: directed pulse scenarios plus a
//   randomized run, all compared cycle by cycle against a queue-based model
//   that expands each captured configuration into its list of beats.
module tb_axis_pulse_gen;

  localparam int D    = 16;
  localparam int PW   = 16;
  localparam int CFGW = 2*PW + 3*D + 1;

  logic            aclk = 1'b0;
  logic            areset;
  logic [CFGW-1:0] cfg_data;
  logic [2:0]      case_id;
  logic [31:0]     sts_data;
  logic            tready;
  logic [D-1:0]    tdata;
  logic            tvalid;
  logic            tlast;

  axis_pulse_gen #(
    .AXIS_TDATA_WIDTH(D),
    .PULSE_WIDTH(PW),
    .CNTR_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_data(cfg_data),
    .case_id(case_id),
    .sts_data(sts_data),
    .m_axis_tready(tready),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int st;
    int data;
    bit last;
  } beat_t;

  int          checks   = 0;
  int          failures = 0;
  beat_t       q[$];
  bit          m_active;
  int unsigned m_sts;
  int          log_q[$];

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  task automatic set_cfg(input int r, input int w, input int lo, input int hi,
                         input int st, input bit en);
    cfg_data = {en, st[15:0], hi[15:0], lo[15:0], w[15:0], r[15:0]};
  endtask

  function automatic void push_beat(input int st, input int data);
    beat_t b;
    b.st = st; b.data = data; b.last = 1'b0;
    q.push_back(b);
  endfunction

  // Expand one configuration into the full pulse.
  function automatic void build(input logic [CFGW-1:0] c);
    int ramp, width, low, high, step, lvl;
    ramp  = int'(c[15:0]);
    width = int'(c[31:16]);
    low   = int'($signed(c[47:32]));
    high  = int'($signed(c[63:48]));
    step  = int'(c[79:64]);
    for (int i = 0; i < width / 2; i++) push_beat(1, low);
    lvl = low;
    for (int i = 0; i < ramp; i++) begin
      lvl = lvl + step;
      if (lvl > high) lvl = high;
      push_beat(2, lvl);
    end
    for (int i = 0; i < width; i++) push_beat(3, high);
    lvl = high;
    for (int i = 0; i < ramp; i++) begin
      lvl = lvl - step;
      if (lvl < low) lvl = low;
      push_beat(4, lvl);
    end
    for (int i = 0; i < width / 2; i++) push_beat(5, low);
    if (q.size() == 0) push_beat(1, low);
    q[q.size()-1].last = 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_active = 1'b0;
    m_sts    = 0;
  endfunction

  // One clock: update the model with the inputs seen at the edge, then
  // compare every output on the following falling edge.
  task automatic tick();
    logic [CFGW-1:0] c;
    bit    rdy;
    beat_t b;
    logic [15:0] ed;
    c   = cfg_data;
    rdy = tready;
    if (tvalid && tready) log_q.push_back(int'($signed(tdata)));
    @(posedge aclk);
    if (!m_active) begin
      if (c[CFGW-1]) begin
        build(c);
        m_active = 1'b1;
      end
    end else if (rdy) begin
      b = q.pop_front();
      if (b.last) begin
        m_sts++;
        if (c[CFGW-1]) build(c);
        else m_active = 1'b0;
      end
    end
    @(negedge aclk);
    check_val("tvalid", tvalid, m_active);
    check_val("sts_data", sts_data, m_sts);
    if (m_active) begin
      ed = q[0].data[15:0];
      check_val("tdata", tdata, ed);
      check_val("tlast", tlast, q[0].last);
      check_val("case_id", case_id, q[0].st);
    end else begin
      check_val("case_id_idle", case_id, 0);
    end
  endtask

  task automatic run_until_idle(input int max, input bit toggle);
    int n;
    n = 0;
    while ((m_active || tvalid) && n < max) begin
      if (toggle) tready = ~tready;
      tick();
      n++;
    end
    check_val("drain_idle", tvalid, 0);
  endtask

  task automatic wait_state(input int st, input int max);
    int n;
    n = 0;
    while (case_id != st[2:0] && n < max) begin
      tick();
      n++;
    end
    check_val("reach_state", case_id, st);
  endtask

  int exp1[12] = '{0, 0, 60, 100, 100, 100, 100, 100, 40, 0, 0, 0};
  int sts_mark;

  initial begin
    areset   = 1'b1;
    tready   = 1'b0;
    cfg_data = '0;
    model_reset();
    repeat (2) @(negedge aclk);
    check_val("rst_tvalid", tvalid, 0);
    check_val("rst_tlast", tlast, 0);
    check_val("rst_tdata", tdata, 0);
    check_val("rst_case", case_id, 0);
    check_val("rst_sts", sts_data, 0);
    areset = 1'b0;

    // 1: reference pulse, always ready
    tready = 1'b1;
    set_cfg(2, 4, 0, 100, 60, 1'b1);
    log_q.delete();
    tick();
    check_val("t1_latency", tvalid, 1);
    set_cfg(2, 4, 0, 100, 60, 1'b0);
    run_until_idle(100, 1'b0);
    check_val("t1_len", log_q.size(), 12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) check_val("t1_beat", log_q[i], exp1[i]);
    check_val("t1_sts", sts_data, 1);

    // 2: same pulse with tready toggling every cycle
    log_q.delete();
    tready = 1'b1;
    set_cfg(2, 4, 0, 100, 60, 1'b1);
    tick();
    set_cfg(2, 4, 0, 100, 60, 1'b0);
    run_until_idle(100, 1'b1);
    check_val("t2_len", log_q.size(), 12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) check_val("t2_beat", log_q[i], exp1[i]);
    tready = 1'b1;

    // 3: config change mid-pulse, then enable dropped during HIGH
    set_cfg(1, 4, 10, 200, 50, 1'b1);
    wait_state(3, 50);
    sts_mark = sts_data;
    set_cfg(2, 2, -5, 30, 7, 1'b1);
    for (int n = 0; n < 50 && !(case_id == 3'd3 && sts_data == sts_mark + 1); n++) tick();
    check_val("t3_second_high", tdata, 30);
    set_cfg(2, 2, -5, 30, 7, 1'b0);
    run_until_idle(50, 1'b0);
    check_val("t3_idle_case", case_id, 0);

    // 4: HIGH-only pulse, then back-to-back all-zero pulses
    log_q.delete();
    set_cfg(0, 1, 0, 77, 5, 1'b1);
    tick();
    set_cfg(0, 1, 0, 77, 5, 1'b0);
    run_until_idle(20, 1'b0);
    check_val("t4_len", log_q.size(), 1);
    if (log_q.size() > 0) check_val("t4_beat", log_q[0], 77);
    sts_mark = sts_data;
    set_cfg(0, 0, -3, 9, 1, 1'b1);
    repeat (6) tick();
    check_val("t4_train_sts", sts_data, sts_mark + 5);
    set_cfg(0, 0, -3, 9, 1, 1'b0);
    run_until_idle(20, 1'b0);

    // 5: full-scale ramp saturation
    log_q.delete();
    set_cfg(3, 2, -32768, 32767, 40000, 1'b1);
    tick();
    set_cfg(3, 2, -32768, 32767, 40000, 1'b0);
    run_until_idle(50, 1'b0);
    check_val("t5_len", log_q.size(), 10);
    if (log_q.size() == 10) begin
      check_val("t5_up0", log_q[1], 7232);
      check_val("t5_up1", log_q[2], 32767);
      check_val("t5_up2", log_q[3], 32767);
      check_val("t5_dn0", log_q[6], -7233);
      check_val("t5_dn1", log_q[7], -32768);
      check_val("t5_dn2", log_q[8], -32768);
    end

    // 6: asynchronous reset in the middle of RAMP_UP
    set_cfg(4, 4, 0, 1000, 100, 1'b1);
    wait_state(2, 50);
    #2 areset = 1'b1;
    #1;
    check_val("t6_tvalid", tvalid, 0);
    check_val("t6_tlast", tlast, 0);
    check_val("t6_case", case_id, 0);
    check_val("t6_sts", sts_data, 0);
    model_reset();
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    tick();
    check_val("t6_restart", case_id, 1);
    repeat (5) tick();
    set_cfg(4, 4, 0, 1000, 100, 1'b0);
    run_until_idle(100, 1'b0);

    // Randomized traffic: config, enable and backpressure all vary.
    set_cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom, $urandom, $urandom, 1'b1);
    for (int n = 0; n < 800; n++) begin
      tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom, $urandom, $urandom,
                cfg_data[CFGW-1]);
      if ($urandom_range(0, 19) == 0) cfg_data[CFGW-1] = ~cfg_data[CFGW-1];
      tick();
    end
    cfg_data[CFGW-1] = 1'b0;
    tready = 1'b1;
    run_until_idle(100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
